// File: rtl/alu_seq.sv
// Multi-cycle ALU feeding the accumulator: single-cycle logic/arithmetic ops,
// shift-add multiply and restoring divide, with a one-cycle done strobe.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] alu_out,
    output logic             done,
    output logic             busy,
    output logic             zero,
    output logic             carry,
    output logic             div_zero
);

    localparam logic [3:0] OP_PASSB = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_SHR   = 4'd8;
    localparam logic [3:0] OP_INC   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_DIV   = 4'd11;

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;   // product high half / partial remainder
    logic [WIDTH-1:0] q_reg;     // multiplier-then-product low half / dividend-then-quotient
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_reg} + {1'b0, (q_reg[0] ? a_reg : {WIDTH{1'b0}})};
        div_shift = {acc_reg, q_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_reg};
        div_ge    = (div_shift >= {1'b0, b_reg});
    end

    logic [WIDTH-1:0] fin_res;
    logic             fin_carry;
    logic             fin_dz;
    logic [WIDTH:0]   wide;

    always_comb begin
        fin_res   = a_reg;
        fin_carry = 1'b0;
        fin_dz    = 1'b0;
        wide      = '0;
        case (op_reg)
            OP_PASSB: fin_res = b_reg;
            OP_ADD: begin
                wide      = {1'b0, a_reg} + {1'b0, b_reg};
                fin_res   = wide[WIDTH-1:0];
                fin_carry = wide[WIDTH];
            end
            OP_SUB: begin
                fin_res   = a_reg - b_reg;
                fin_carry = (a_reg < b_reg);
            end
            OP_AND: fin_res = a_reg & b_reg;
            OP_OR:  fin_res = a_reg | b_reg;
            OP_XOR: fin_res = a_reg ^ b_reg;
            OP_NOT: fin_res = ~a_reg;
            OP_SHL: begin
                fin_res   = {a_reg[WIDTH-2:0], 1'b0};
                fin_carry = a_reg[WIDTH-1];
            end
            OP_SHR: begin
                fin_res   = {1'b0, a_reg[WIDTH-1:1]};
                fin_carry = a_reg[0];
            end
            OP_INC: begin
                wide      = {1'b0, a_reg} + (WIDTH+1)'(1);
                fin_res   = wide[WIDTH-1:0];
                fin_carry = wide[WIDTH];
            end
            OP_MUL: begin
                fin_res   = q_reg;
                fin_carry = |acc_reg;
            end
            OP_DIV: begin
                if (b_reg == '0) begin
                    fin_res = {WIDTH{1'b1}};
                    fin_dz  = 1'b1;
                end else begin
                    fin_res = q_reg;
                end
            end
            default: fin_res = a_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
            alu_out   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // The done cycle is already IDLE, so a new start is accepted there.
                    busy <= start;
                    if (start) begin
                        op_reg <= op;
                        a_reg  <= a_in;
                        b_reg  <= b_in;
                        acc_reg <= '0;
                        cnt_reg <= CNT_W'(WIDTH);
                        if (op == OP_MUL) begin
                            q_reg     <= b_in;
                            state_reg <= ITER;
                        end else if (op == OP_DIV && b_in != '0) begin
                            q_reg     <= a_in;
                            state_reg <= ITER;
                        end else begin
                            state_reg <= FIN;
                        end
                    end
                end
                ITER: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (op_reg == OP_MUL) begin
                        {acc_reg, q_reg} <= {mul_sum, q_reg[WIDTH-1:1]};
                    end else begin
                        acc_reg <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        q_reg   <= {q_reg[WIDTH-2:0], div_ge};
                    end
                    if (cnt_reg == CNT_W'(1))
                        state_reg <= FIN;
                end
                FIN: begin
                    alu_out   <= fin_res;
                    zero      <= (fin_res == '0);
                    carry     <= fin_carry;
                    div_zero  <= fin_dz;
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus random ops checked against an
// arithmetic reference model.
module tb_alu_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] alu_out;
    logic        done;
    logic        busy;
    logic        zero;
    logic        carry;
    logic        div_zero;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    alu_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .alu_out(alu_out), .done(done),
        .busy(busy), .zero(zero), .carry(carry), .div_zero(div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {div_zero, carry, result}
    function automatic logic [17:0] model(input int unsigned o, input int unsigned a, input int unsigned b);
        int unsigned r, s;
        logic c, dz;
        r = a; c = 1'b0; dz = 1'b0;
        case (o)
            0:  r = b;
            1:  begin s = a + b; r = s & 32'hFFFF; c = (s > 32'hFFFF); end
            2:  begin r = (a - b) & 32'hFFFF; c = (a < b); end
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = (~a) & 32'hFFFF;
            7:  begin r = (a * 2) & 32'hFFFF; c = (a >= 32'h8000); end
            8:  begin r = a / 2; c = (a % 2) == 1; end
            9:  begin s = a + 1; r = s & 32'hFFFF; c = (s > 32'hFFFF); end
            10: begin s = a * b; r = s % 65536; c = (s / 65536) != 0; end
            11: begin
                if (b == 0) begin r = 32'hFFFF; dz = 1'b1; end
                else r = a / b;
            end
            default: r = a;
        endcase
        return {dz, c, r[15:0]};
    endfunction

    task automatic run_op(input int unsigned o, input int unsigned a, input int unsigned b, input bit disturb);
        logic [17:0] e;
        int exp_lat;
        int n;
        e = model(o, a, b);
        exp_lat = (o == 10 || (o == 11 && b != 0)) ? 17 : 1;
        op = o[3:0]; a_in = a[15:0]; b_in = b[15:0]; start = 1'b1;
        tick();
        start = 1'b0;
        for (n = 1; n <= 40; n++) begin
            tick();
            if (done) break;
            check("busy_wait", busy, 1);
            if (disturb) begin
                start = 1'b1; op = 4'd1;
                a_in = 16'($urandom); b_in = 16'($urandom);
            end
        end
        start = 1'b0;
        check("latency", n, exp_lat);
        check("busy_done", busy, 1);
        check("alu_out", alu_out, e[15:0]);
        check("zero", zero, e[15:0] == 16'h0);
        check("carry", carry, e[16]);
        check("div_zero", div_zero, e[17]);
        $display("op=%0d a=%04h b=%04h -> out=%04h z=%0b c=%0b dz=%0b lat=%0d",
                 o, a[15:0], b[15:0], alu_out, zero, carry, div_zero, n);
        tick();
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
        check("hold", alu_out, e[15:0]);
    endtask

    initial begin
        int dn;
        int unsigned ro, ra, rb;
        reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
        tick(); tick();
        check("rst_out", alu_out, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {zero, carry, div_zero}, 0);
        reset = 1'b0;
        tick();

        run_op(1, 16'hFFFF, 16'h0001, 1'b0);
        run_op(2, 3, 5, 1'b0);
        run_op(7, 16'h8001, 0, 1'b0);
        run_op(10, 300, 300, 1'b0);
        run_op(10, 12, 11, 1'b0);
        run_op(11, 1000, 7, 1'b0);
        run_op(11, 5, 0, 1'b0);
        run_op(10, 300, 300, 1'b1);

        // Reset in the middle of a multiply
        op = 4'd10; a_in = 16'd300; b_in = 16'd300; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out", alu_out, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_flags", {zero, carry, div_zero}, 0);
        dn = 0;
        repeat (20) begin tick(); if (done) dn++; end
        check("abort_no_done", dn, 0);
        $display("reset during MUL iteration 8 -> dones afterwards=%0d", dn);
        run_op(1, 2, 2, 1'b0);

        // Back-to-back PASSB with start held high
        op = 4'd0; b_in = 16'd1; start = 1'b1;
        tick();
        b_in = 16'd2;
        tick();
        check("b2b_done1", done, 1);
        check("b2b_out1", alu_out, 1);
        b_in = 16'd3;
        tick();
        check("b2b_gap", done, 0);
        start = 1'b0;
        tick();
        check("b2b_done2", done, 1);
        check("b2b_out2", alu_out, 3);
        tick();
        check("b2b_idle", done, 0);
        check("b2b_hold", alu_out, 3);
        $display("back-to-back PASSB 1,2,3 -> final out=%04h", alu_out);

        for (int i = 0; i < 30; i++) begin
            ro = $urandom_range(0, 15);
            ra = $urandom & 32'hFFFF;
            rb = ($urandom_range(0, 5) == 0) ? 0 : ($urandom & 32'hFFFF);
            run_op(ro, ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
